// File: rtl/isqrt_seq_responder_if.sv
// Strobe interface between an isqrt initiator and the sequential responder.
// There is no ready: the initiator keeps at most one request outstanding.
interface isqrt_seq_responder_if;
   logic        x_vld;
   logic [31:0] x;
   logic        y_vld;
   logic [15:0] y;
   logic        busy;
   logic        drop_err;

   modport master (output x_vld, x, input y_vld, y, busy, drop_err);
   modport slave  (input x_vld, x, output y_vld, y, busy, drop_err);
endinterface

// File: rtl/isqrt_seq_responder.sv
// Sequential 32-bit integer square root, one digit-by-digit step per cycle.
// A result appears 17 cycles after acceptance; requests arriving while busy are dropped.
module isqrt_seq_responder (
   input  logic                  clk,
   input  logic                  rst,
   isqrt_seq_responder_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] op;
   logic [17:0] rem;
   logic [15:0] root;
   logic [15:0] y_q;
   logic        drop_q;
   logic        accept;

   logic [19:0] rem_sh;
   logic [19:0] trial;
   logic        ge;
   logic [17:0] diff;
   logic [17:0] rem_nxt;
   logic [15:0] root_nxt;

   // A request is taken in IDLE and also in DONE, which allows back-to-back issue.
   assign accept = bus.x_vld && (state != BUSY);

   always_comb begin
      rem_sh   = {rem, op[31:30]};
      trial    = {2'b00, root, 2'b01};
      ge       = (rem_sh >= trial);
      // Only taken when ge, so the true difference always fits in 18 bits.
      diff     = rem_sh[17:0] - trial[17:0];
      rem_nxt  = ge ? diff : rem_sh[17:0];
      root_nxt = {root[14:0], ge};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         y_q    <= 16'd0;
         drop_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= 4'd0;
         else if (state == BUSY)
            cnt <= cnt + 4'd1;
         if (state == BUSY && cnt == 4'd15)
            y_q <= root_nxt;
         if (state == BUSY && bus.x_vld)
            drop_q <= 1'b1;
      end
   end

   // NOTE: the datapath registers carry no reset; they are always loaded on
   // acceptance before being used, so resetting them would only add fan-out.
   always_ff @(posedge clk) begin
      if (accept) begin
         op   <= bus.x;
         rem  <= 18'd0;
         root <= 16'd0;
      end else if (state == BUSY) begin
         op   <= {op[29:0], 2'b00};
         rem  <= rem_nxt;
         root <= root_nxt;
      end
   end

   // NOTE: every branch assigns state_nxt after the default, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.x_vld) state_nxt = BUSY;
         BUSY:    if (cnt == 4'd15) state_nxt = DONE;
         DONE:    state_nxt = bus.x_vld ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = (state == BUSY);
      bus.y_vld    = (state == DONE);
      bus.y        = y_q;
      bus.drop_err = drop_q;
   end

endmodule

// File: doc/isqrt_seq_responder.md
ISQRT_SEQ_RESPONDER -- requirements
Module: isqrt_seq_responder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 x_vld  input  1  request strobe; x is valid in this cycle.
REQ-005 x  input  32  unsigned radicand.
REQ-006 y_vld  output  1  one-cycle result strobe.
REQ-007 y  output  16  floor(sqrt(x)) of the accepted request.
REQ-008 busy  output  1  high while a computation is in progress (state BUSY).
REQ-009 drop_err  output  1  sticky flag; set when a request is dropped.

Function
REQ-010 The block SHALL implement the responder side of the isqrt strobe interface: no ready signal; the initiator issues at most one outstanding request.
REQ-011 The FSM SHALL have states IDLE, BUSY, DONE, and a 4-bit iteration counter cnt.
REQ-012 IDLE: x_vld=1 -> capture x, clear root and remainder, cnt=0, go to BUSY; otherwise stay in IDLE.
REQ-013 BUSY: perform one iteration per cycle; cnt increments; at cnt==15 the iteration completes and the FSM goes to DONE.
REQ-014 DONE: y_vld=1 for exactly this cycle; x_vld=1 in the same cycle -> accepted as a new request (go to BUSY, as from IDLE); otherwise go to IDLE.
REQ-015 Latency: request accepted in cycle N -> y_vld high in cycle N+17; throughput one result per 17 cycles with back-to-back issue in the DONE cycle.
REQ-016 Each iteration SHALL use the digit-by-digit method.
REQ-017 Shift the remainder left by 2 and bring in the top two operand bits, then shift the operand left by 2.
REQ-018 Trial value SHALL be {root,2'b01}; if remainder >= trial, then remainder -= trial and root = {root,1}; else root = {root,0}.
REQ-019 The remainder register SHALL be 18 bits and root 16 bits; no overflow occurs for any 32-bit x.
REQ-020 y SHALL equal the final root, registered; it is updated only on entry to DONE and holds its value until the next result.
REQ-021 x_vld=1 while in BUSY SHALL be ignored: the computation in progress is unaffected, no extra y_vld, and drop_err is set to 1.
REQ-022 drop_err SHALL stay 1 until rst.
REQ-023 busy SHALL equal (state==BUSY); it SHALL be 0 in IDLE and DONE.
REQ-024 Every accepted request SHALL produce exactly one y_vld pulse unless rst intervenes.
REQ-025 The result SHALL depend only on the x value captured at acceptance; later changes of x are ignored.

Reset
REQ-026 rst=1 SHALL force state=IDLE, cnt=0, y_vld=0, y=0, busy=0, drop_err=0 on the next posedge.
REQ-027 rst asserted in BUSY or DONE SHALL abort the request; no y_vld is produced for it.
REQ-028 x_vld in the same cycle as rst SHALL be ignored.
REQ-029 The first request may be issued in the cycle after rst deasserts.

Verification
REQ-030 x=0 accepted in cycle N -> y_vld=1, y=0 in cycle N+17 only; busy=1 in cycles N+1..N+16.
REQ-031 x=32'hFFFF_FFFF -> y=16'hFFFF; x=1_000_000 -> y=1000; x=99 -> y=9; x=100 -> y=10; x=1 -> y=1.
REQ-032 Back-to-back:
- x=16 in cycle N -> y_vld=1, y=4 in cycle N+17.
- x=25 issued in cycle N+17 -> y_vld=1, y=5 in cycle N+34.
REQ-033 Drop during BUSY:
- x=49 in cycle N, x=81 in cycle N+5 -> single y_vld, y=7 in cycle N+17.
- drop_err=1 from cycle N+6 and remains 1 until rst.
REQ-034 Reset mid-operation:
- x=400 in cycle N, rst in cycle N+8 -> no y_vld; busy=0, y=0 from cycle N+9.
- x=144 then issued -> y=12 after 17 cycles.
REQ-035 Random regression: at least 10^5 random x values plus all perfect squares k^2 and k^2-1 for k in 1..65535 -> y == floor(sqrt(x)) in every case.
